// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and constants for the run command sequencer.
//   run_state_t  - sequencer FSM states
//   run_status_t - completion status codes reported on the result channel
//   TGT_MIN/MAX  - legal stop-target range accepted by a run command
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WATCH  = 2'd2,
    S_REPORT = 2'd3
  } run_state_t;

  // Code 3 is reserved and never produced.
  typedef enum logic [1:0] {
    ST_OK         = 2'd0,
    ST_BAD_TARGET = 2'd1,
    ST_TIMEOUT    = 2'd2
  } run_status_t;

  localparam logic [2:0] TGT_MIN = 3'd5;
  localparam logic [2:0] TGT_MAX = 3'd6;

  function automatic logic target_legal(input logic [2:0] tgt);
    return (tgt >= TGT_MIN) && (tgt <= TGT_MAX);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: watch-window timer for run_ctrl.
//   clk     - clock, rising edge
//   rst     - asynchronous active-low reset
//   clear   - synchronous clear to zero (priority over en)
//   en      - count one per cycle while high
//   expired - high while the count equals TIMEOUT-1
module cycle_timer #(
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned TMR_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] count;

  // Holds at LAST so expired stays asserted if en lingers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + TMR_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: command sequencer for the counter stage.
//   clk, rst              - clock; asynchronous active-low reset
//   cmd_valid/cmd_ready   - run command handshake, cmd_target = stop value
//   start, stop           - one-cycle pulses to the counter stage
//   counter_in            - counter value returned by the counter stage
//   done_valid/done_ready - result handshake
//   done_status           - OK / BAD_TARGET / TIMEOUT
//   done_count            - counter_in captured at stop or abort
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned TMR_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_target,
  output logic       start,
  output logic       stop,
  input  logic [2:0] counter_in,
  output logic       done_valid,
  input  logic       done_ready,
  output logic [1:0] done_status,
  output logic [2:0] done_count
);

  run_state_t  state, state_nx;
  run_status_t status_q;
  logic [2:0]  target;
  logic [2:0]  count_q;
  logic        accept;
  logic        legal;
  logic        match;
  logic        expired;

  assign accept = cmd_valid && (state == S_IDLE);
  assign legal  = target_legal(cmd_target);
  // Equality only: a wrapped counter simply matches again next lap.
  assign match  = (state == S_WATCH) && (counter_in == target);

  cycle_timer #(
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept && legal),
    .en      (state == S_WATCH),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nx = legal ? S_LAUNCH : S_REPORT;
      end
      S_LAUNCH: state_nx = S_WATCH;
      S_WATCH: begin
        if (match || expired) state_nx = S_REPORT;
      end
      S_REPORT: begin
        if (done_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (state == S_IDLE);
    start      = (state == S_LAUNCH);
    stop       = match;
    done_valid = (state == S_REPORT);
  end

  // Result registers; match is checked before expiry so OK wins a tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      target   <= '0;
      status_q <= ST_OK;
      count_q  <= '0;
    end else if (accept) begin
      if (legal) begin
        target <= cmd_target;
      end else begin
        status_q <= ST_BAD_TARGET;
        count_q  <= '0;
      end
    end else if (match) begin
      status_q <= ST_OK;
      count_q  <= counter_in;
    end else if ((state == S_WATCH) && expired) begin
      status_q <= ST_TIMEOUT;
      count_q  <= counter_in;
    end
  end

  assign done_status = status_q;
  assign done_count  = count_q;

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;

  localparam logic [1:0] E_OK  = 2'd0;
  localparam logic [1:0] E_BAD = 2'd1;
  localparam logic [1:0] E_TMO = 2'd2;

  typedef struct {
    logic [1:0] st;
    logic [2:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_target = '0;
  logic       start, stop;
  logic [2:0] counter_in;
  logic       done_valid;
  logic       done_ready = 1'b0;
  logic [1:0] done_status;
  logic [2:0] done_count;

  logic [2:0] cnt = '0;
  logic       freeze = 1'b0;
  logic [2:0] frz_val = '0;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Counter-stage model: restarts at 0 on start, ramps and wraps otherwise.
  always @(posedge clk) begin
    if (start) cnt <= 3'd0;
    else       cnt <= cnt + 3'd1;
  end
  assign counter_in = freeze ? frz_val : cnt;

  run_ctrl #(.TIMEOUT(8), .TMR_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_target  (cmd_target),
    .start       (start),
    .stop        (stop),
    .counter_in  (counter_in),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .done_status (done_status),
    .done_count  (done_count)
  );

  task automatic test_reset();
    rst = 1'b0; cmd_valid = 1'b0; done_ready = 1'b0;
    #3;
    vectors++;
    if ({cmd_ready, start, stop, done_valid, done_status, done_count} !== 9'b1_0_0_0_00_000) begin
      miscompares++;
      $display("FAIL reset_state: got %b expected 100000000",
               {cmd_ready, start, stop, done_valid, done_status, done_count});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_target5();
    int stops = 0, stop_at = 0, got = 0;
    exp_t e;
    freeze = 1'b0;
    cmd_valid = 1'b1; cmd_target = 3'd5;
    q.push_back('{E_OK, 3'd5});
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL t5_cmd_ready: got %b expected 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++;
    if ({start, stop} !== 2'b10) begin miscompares++; $display("FAIL t5_start: got %b expected 10", {start, stop}); end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done_valid) begin got = i; break; end
      if (stop) begin
        stops++; stop_at = i;
        vectors++;
        if (counter_in !== 3'd5) begin miscompares++; $display("FAIL t5_stop_value: got %0d expected 5", counter_in); end
      end
    end
    vectors++;
    if (stops != 1 || stop_at != 6) begin miscompares++; $display("FAIL t5_stop_pulse: got %0d pulses at %0d expected 1 at 6", stops, stop_at); end
    vectors++;
    if (got != 7) begin miscompares++; $display("FAIL t5_done_latency: got %0d expected 7", got); end
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if ({done_status, done_count} !== {e.st, e.cnt}) begin
        miscompares++;
        $display("FAIL t5_result: got st=%0d cnt=%0d expected st=%0d cnt=%0d", done_status, done_count, e.st, e.cnt);
      end
    end
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    vectors++;
    if ({done_valid, cmd_ready} !== 2'b01) begin miscompares++; $display("FAIL t5_return_idle: got %b expected 01", {done_valid, cmd_ready}); end
  endtask

  task automatic test_hold_back_to_back();
    int got = 0;
    logic early_ready = 1'b0;
    exp_t e;
    freeze = 1'b0;
    cmd_valid = 1'b1; cmd_target = 3'd6;
    q.push_back('{E_OK, 3'd6});
    @(negedge clk);
    cmd_target = 3'd5;           // next command offered and left waiting
    q.push_back('{E_OK, 3'd5});
    for (int i = 1; i <= 40; i++) begin
      if (cmd_ready) early_ready = 1'b1;
      @(negedge clk);
      if (done_valid) begin got = i; break; end
    end
    vectors++;
    if (got != 8 || early_ready) begin
      miscompares++;
      $display("FAIL hold_first_run: got latency %0d early_ready %b expected 8 0", got, early_ready);
    end
    e = (q.size() > 0) ? q[0] : '{2'd3, 3'd7};
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({done_valid, cmd_ready, done_status, done_count} !== {2'b10, e.st, e.cnt}) begin
        miscompares++;
        $display("FAIL hold_stable_%0d: got v=%b r=%b st=%0d cnt=%0d expected v=1 r=0 st=%0d cnt=%0d",
                 k, done_valid, cmd_ready, done_status, done_count, e.st, e.cnt);
      end
      @(negedge clk);
    end
    done_ready = 1'b1;
    if (q.size() > 0) void'(q.pop_front());
    @(negedge clk);
    vectors++;
    if ({cmd_ready, done_valid} !== 2'b10) begin miscompares++; $display("FAIL b2b_idle: got %b expected 10", {cmd_ready, done_valid}); end
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++;
    if (start !== 1'b1) begin miscompares++; $display("FAIL b2b_start: got %b expected 1", start); end
    got = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done_valid) begin got = i; break; end
    end
    vectors++;
    if (got != 7) begin miscompares++; $display("FAIL b2b_latency: got %0d expected 7", got); end
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if ({done_status, done_count} !== {e.st, e.cnt}) begin
        miscompares++;
        $display("FAIL b2b_result: got st=%0d cnt=%0d expected st=%0d cnt=%0d", done_status, done_count, e.st, e.cnt);
      end
    end
    @(negedge clk);
    done_ready = 1'b0;
    vectors++;
    if ({done_valid, cmd_ready} !== 2'b01) begin miscompares++; $display("FAIL ready_high_one_cycle: got %b expected 01", {done_valid, cmd_ready}); end
  endtask

  task automatic test_bad_target();
    logic [2:0] tgts [4] = '{3'd3, 3'd4, 3'd7, 3'd0};
    exp_t e;
    foreach (tgts[j]) begin
      cmd_valid = 1'b1; cmd_target = tgts[j];
      q.push_back('{E_BAD, 3'd0});
      @(negedge clk);
      cmd_valid = 1'b0;
      vectors++;
      if ({done_valid, start, stop} !== 3'b100) begin
        miscompares++;
        $display("FAIL bad_%0d_flags: got %b expected 100", tgts[j], {done_valid, start, stop});
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if ({done_status, done_count} !== {e.st, e.cnt}) begin
          miscompares++;
          $display("FAIL bad_%0d_result: got st=%0d cnt=%0d expected st=%0d cnt=%0d",
                   tgts[j], done_status, done_count, e.st, e.cnt);
        end
      end
      done_ready = 1'b1;
      @(negedge clk);
      done_ready = 1'b0;
      vectors++;
      if ({done_valid, cmd_ready, start} !== 3'b010) begin
        miscompares++;
        $display("FAIL bad_%0d_idle: got %b expected 010", tgts[j], {done_valid, cmd_ready, start});
      end
    end
  endtask

  task automatic test_timeout();
    int stops = 0, got = 0;
    exp_t e;
    freeze = 1'b1; frz_val = 3'd2;
    cmd_valid = 1'b1; cmd_target = 3'd5;
    q.push_back('{E_TMO, 3'd2});
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++;
    if (start !== 1'b1) begin miscompares++; $display("FAIL tmo_start: got %b expected 1", start); end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done_valid) begin got = i; break; end
      if (stop) stops++;
    end
    vectors++;
    if (got != 9 || stops != 0) begin
      miscompares++;
      $display("FAIL tmo_latency: got %0d (stops %0d) expected 9 (stops 0)", got, stops);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if ({done_status, done_count} !== {e.st, e.cnt}) begin
        miscompares++;
        $display("FAIL tmo_result: got st=%0d cnt=%0d expected st=%0d cnt=%0d", done_status, done_count, e.st, e.cnt);
      end
    end
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int got = 0;
    exp_t e;
    freeze = 1'b1; frz_val = 3'd4;
    cmd_valid = 1'b1; cmd_target = 3'd6;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({cmd_ready, start, stop, done_valid, done_status, done_count} !== 9'b1_0_0_0_00_000) begin
      miscompares++;
      $display("FAIL midrun_reset: got %b expected 100000000",
               {cmd_ready, start, stop, done_valid, done_status, done_count});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({cmd_ready, stop} !== 2'b10) begin miscompares++; $display("FAIL midrun_release: got %b expected 10", {cmd_ready, stop}); end
    freeze = 1'b0;
    cmd_valid = 1'b1; cmd_target = 3'd6;
    q.push_back('{E_OK, 3'd6});
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done_valid) begin got = i; break; end
    end
    vectors++;
    if (got != 8) begin miscompares++; $display("FAIL midrun_rerun_latency: got %0d expected 8", got); end
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if ({done_status, done_count} !== {e.st, e.cnt}) begin
        miscompares++;
        $display("FAIL midrun_rerun_result: got st=%0d cnt=%0d expected st=%0d cnt=%0d", done_status, done_count, e.st, e.cnt);
      end
    end
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_target5();
    test_hold_back_to_back();
    test_bad_target();
    test_timeout();
    test_reset_mid_run();
    vectors++;
    if (q.size() != 0) begin miscompares++; $display("FAIL scoreboard_drain: got %0d left expected 0", q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Upstream command sequencer for the counter FSM stage. It accepts a run command carrying a stop target, pulses `start`, watches the returned counter, and asserts `stop` on the exact cycle the counter equals the target. It then reports a completion status through a valid/ready result channel. It owns the full start/stop protocol of one run, so software-facing logic never drives the counter stage directly.

## Interface
- `TIMEOUT`, 32: maximum cycles spent in WATCH before aborting the run (≥ 2).
- `TMR_W`, 8: width of the watch-cycle timer; must hold `TIMEOUT`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_target`  in  3  counter value at which to stop; legal values 5 and 6.
- `start`  out  1  one-cycle pulse to the counter stage.
- `stop`  out  1  one-cycle pulse to the counter stage.
- `counter_in`  in  3  counter value from the counter stage.
- `done_valid`  out  1  result available; held until accepted.
- `done_ready`  in  1  consumer accepts result.
- `done_status`  out  2  result code: OK, BAD_TARGET, or TIMEOUT.
- `done_count`  out  3  `counter_in` captured at stop or abort.

## Operation
- States: IDLE, LAUNCH, WATCH, REPORT.
- IDLE:
  - `cmd_ready=1`.
  - On handshake with target 5 or 6: latch the target, clear the timer, go to LAUNCH.
  - On handshake with any other target: load status BAD_TARGET and count 0, go to REPORT. No `start` is issued.
- LAUNCH: `start=1` for exactly this cycle; go to WATCH.
- WATCH:
  - `stop = (counter_in == target)`. This is combinational from the registered target and must be asserted only in WATCH.
  - When `stop` is high: load status OK and `done_count=counter_in`, go to REPORT.
  - Otherwise the timer increments. When the timer reaches `TIMEOUT-1` without a match: load status TIMEOUT and `done_count=counter_in`, go to REPORT. `stop` is never asserted on a timeout.
- REPORT:
  - `done_valid=1`; `done_status` and `done_count` stay stable until `done_valid & done_ready`.
  - On handshake, go to IDLE.
- `cmd_ready=0` in every state except IDLE. Commands offered outside IDLE wait; they are never dropped or accepted early.
- `counter_in` is 3-bit unsigned and wraps 7→0. The compare is equality only, so a counter that wraps past the target simply matches again on the next lap.
- Status codes: OK=0, BAD_TARGET=1, TIMEOUT=2; 3 is reserved and never driven.

## Timing
- Reset (async assert, sync release):
  - state IDLE; `start=0`, `stop=0`, `done_valid=0`, `done_status=0`, `done_count=0`, timer 0.
  - `cmd_ready=1` while in reset.
- Command handshake at edge N:
  - `start` is high during cycle N+1.
  - The earliest `stop` is in cycle N+2.
- Result handshake at edge M: state is IDLE at M+1, where `cmd_ready=1`.
- Fastest result: `done_valid` rises at N+1 for a BAD_TARGET command.
- Back-to-back runs: a new command is accepted the cycle after the result handshake.
- Timer runs only in WATCH. A TIMEOUT result has `done_valid` rising exactly `TIMEOUT` cycles after WATCH entry.
- `stop` and the timeout expire in the same cycle: OK wins, and `stop` is asserted.
- `done_ready` held high on REPORT entry: the result completes in one cycle.
- Reset asserted mid-run: all outputs return to reset values immediately; no `stop` is emitted.

## Structure
- Package `run_ctrl_pkg`: `run_state_t` enum (2-bit), `run_status_t` codes, and `TGT_MIN=3'd5` / `TGT_MAX=3'd6`.
- Sub-module `cycle_timer`:
  - Parameterised `TMR_W`, with `clear`, `en`, and an `expired` compare against `TIMEOUT-1`.
  - Same async active-low reset as the parent.
  - Instanced once.

## Test plan
- Target 5, counter model ramps 0,1,2,…: `start` one cycle after acceptance; `stop` only in the cycle `counter_in=5`; result OK with count 5.
- Target 6 with `done_ready` held low 4 cycles: `done_valid`, OK, and count 6 held stable; `cmd_ready=0` throughout; next command accepted the cycle after `done_ready`.
- Target 3: no `start` or `stop`; result BAD_TARGET with count 0 one cycle after acceptance.
- Target 5 with `counter_in` frozen at 2 and `TIMEOUT=8`: `stop` never asserted; TIMEOUT result with count 2 exactly 8 cycles after WATCH entry.
- Reset pulse in WATCH with `counter_in=4`: all outputs zero asynchronously; after release `cmd_ready=1` and a fresh target-6 run completes with OK.
